// File: rtl/gshare_fetch_predictor.sv
// Fetch-stage gshare branch predictor: PHT of 2-bit counters indexed by PC^GHR,
// direct-mapped BTB for targets, speculative GHR with repair from the resolving stage.
module gshare_fetch_predictor #(
  parameter int HIST_BITS    = 8,
  parameter int BTB_IDX_BITS = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 stall_pipeline,
  input  logic [15:0]          fetch_pc,
  output logic                 pred_taken,
  output logic [15:0]          pred_target,
  output logic [HIST_BITS-1:0] pred_history,
  output logic [15:0]          next_pc,
  input  logic                 update_valid,
  input  logic [15:0]          update_pc,
  input  logic [HIST_BITS-1:0] update_history,
  input  logic                 update_taken,
  input  logic [15:0]          update_target,
  input  logic                 update_mispredict
);

  localparam int PHT_N = 1 << HIST_BITS;
  localparam int BTB_N = 1 << BTB_IDX_BITS;
  localparam int TAG_W = 15 - BTB_IDX_BITS;

  logic [1:0]           r_pht     [PHT_N];
  logic [BTB_N-1:0]     r_btb_vld;
  logic [TAG_W-1:0]     r_btb_tag [BTB_N];
  logic [15:0]          r_btb_tgt [BTB_N];
  logic [HIST_BITS-1:0] r_ghr;

  logic [HIST_BITS-1:0]    w_pidx;
  logic [HIST_BITS-1:0]    w_uidx;
  logic [BTB_IDX_BITS-1:0] w_bidx;
  logic [BTB_IDX_BITS-1:0] w_ubidx;
  logic                    w_btb_hit;
  logic                    w_unused;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'b11) ? cnt : cnt + 2'b01;
    return (cnt == 2'b00) ? cnt : cnt - 2'b01;
  endfunction

  // Instructions are halfword aligned, so pc[0] never participates in indexing.
  assign w_unused = ^{fetch_pc[0], update_pc[0]};

  assign w_pidx    = fetch_pc[HIST_BITS:1] ^ r_ghr;
  assign w_bidx    = fetch_pc[BTB_IDX_BITS:1];
  assign w_uidx    = update_pc[HIST_BITS:1] ^ update_history;
  assign w_ubidx   = update_pc[BTB_IDX_BITS:1];
  assign w_btb_hit = r_btb_vld[w_bidx] && (r_btb_tag[w_bidx] == fetch_pc[15:BTB_IDX_BITS+1]);

  assign pred_taken   = w_btb_hit && r_pht[w_pidx][1];
  assign pred_target  = w_btb_hit ? r_btb_tgt[w_bidx] : 16'h0000;
  assign pred_history = r_ghr;
  assign next_pc      = pred_taken ? pred_target : fetch_pc + 16'd2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ghr <= '0;
    end else if (update_valid && update_mispredict) begin
      r_ghr <= {update_history[HIST_BITS-2:0], update_taken};
    end else if (!stall_pipeline && w_btb_hit) begin
      r_ghr <= {r_ghr[HIST_BITS-2:0], pred_taken};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PHT_N; i++) r_pht[i] <= 2'b01;
    end else if (update_valid) begin
      r_pht[w_uidx] <= sat_step(r_pht[w_uidx], update_taken);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_btb_vld <= '0;
    end else if (update_valid && update_taken) begin
      r_btb_vld[w_ubidx] <= 1'b1;
    end
  end

  // Tag/target are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    if (update_valid && update_taken) begin
      r_btb_tag[w_ubidx] <= update_pc[15:BTB_IDX_BITS+1];
      r_btb_tgt[w_ubidx] <= update_target;
    end
  end

endmodule

// File: tb/tb_gshare_fetch_predictor.sv
// Bench for gshare_fetch_predictor: abstract array model checked every negedge,
// plus directed scenarios with hand-computed literal expectations.
module tb_gshare_fetch_predictor;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        stall_pipeline;
  logic [15:0] fetch_pc;
  logic        pred_taken;
  logic [15:0] pred_target;
  logic [7:0]  pred_history;
  logic [15:0] next_pc;
  logic        update_valid;
  logic [15:0] update_pc;
  logic [7:0]  update_history;
  logic        update_taken;
  logic [15:0] update_target;
  logic        update_mispredict;

  int n_cmp = 0;
  int n_mis = 0;

  gshare_fetch_predictor #(.HIST_BITS(8), .BTB_IDX_BITS(4)) dut (
    .clk(clk), .reset_n(reset_n), .stall_pipeline(stall_pipeline), .fetch_pc(fetch_pc),
    .pred_taken(pred_taken), .pred_target(pred_target), .pred_history(pred_history),
    .next_pc(next_pc), .update_valid(update_valid), .update_pc(update_pc),
    .update_history(update_history), .update_taken(update_taken),
    .update_target(update_target), .update_mispredict(update_mispredict)
  );

  always #5 clk = ~clk;

  // Abstract model state: plain integer arrays.
  int m_pht [256];
  bit m_vld [16];
  int m_tag [16];
  int m_tgt [16];
  int m_ghr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mpredict(input int pc, output int tk, output int tg, output int npc);
    int b, p;
    bit hit;
    b   = (pc >> 1) % 16;
    p   = ((pc >> 1) % 256) ^ m_ghr;
    hit = m_vld[b] && (m_tag[b] == (pc >> 5));
    tk  = (hit && m_pht[p] >= 2) ? 1 : 0;
    tg  = hit ? m_tgt[b] : 0;
    npc = tk ? tg : (pc + 2) % 65536;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 256; i++) m_pht[i] = 1;
      for (int i = 0; i < 16; i++) begin m_vld[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; end
      m_ghr = 0;
    end else begin
      int tk, tg, npc, b, u, ng;
      bit hit;
      mpredict(int'(fetch_pc), tk, tg, npc);
      b   = (int'(fetch_pc) >> 1) % 16;
      hit = m_vld[b] && (m_tag[b] == (int'(fetch_pc) >> 5));
      ng  = m_ghr;
      if (update_valid && update_mispredict) ng = ((int'(update_history) * 2) + int'(update_taken)) % 256;
      else if (!stall_pipeline && hit) ng = ((m_ghr * 2) + tk) % 256;
      if (update_valid) begin
        u = ((int'(update_pc) >> 1) % 256) ^ int'(update_history);
        if (update_taken) m_pht[u] = (m_pht[u] == 3) ? 3 : m_pht[u] + 1;
        else              m_pht[u] = (m_pht[u] == 0) ? 0 : m_pht[u] - 1;
      end
      if (update_valid && update_taken) begin
        u = (int'(update_pc) >> 1) % 16;
        m_vld[u] = 1;
        m_tag[u] = int'(update_pc) >> 5;
        m_tgt[u] = int'(update_target);
      end
      m_ghr = ng;
    end
  end

  always @(negedge clk) begin
    int tk, tg, npc;
    mpredict(int'(fetch_pc), tk, tg, npc);
    chk("mdl_taken",   32'(pred_taken),   32'(tk));
    chk("mdl_target",  32'(pred_target),  32'(tg));
    chk("mdl_history", 32'(pred_history), 32'(m_ghr));
    chk("mdl_next_pc", 32'(next_pc),      32'(npc));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic v, input logic [15:0] pc, input logic [7:0] h,
                     input logic t, input logic [15:0] tgt, input logic mp);
    update_valid = v; update_pc = pc; update_history = h;
    update_taken = t; update_target = tgt; update_mispredict = mp;
  endtask

  initial begin
    stall_pipeline = 1'b0;
    fetch_pc = 16'h0010;
    upd(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 1'b0);
    #1 reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    #1;
    chk("rst_taken",   32'(pred_taken),   32'h0);
    chk("rst_target",  32'(pred_target),  32'h0);
    chk("rst_history", 32'(pred_history), 32'h00);
    chk("rst_next_pc", 32'(next_pc),      32'h0012);

    // Train pc 0x0010 twice taken, fetch frozen so the GHR stays 0.
    stall_pipeline = 1'b1;
    upd(1'b1, 16'h0010, 8'h00, 1'b1, 16'h0040, 1'b0);
    tick(); tick();
    update_valid = 1'b0;
    #1;
    chk("train_taken",   32'(pred_taken),  32'h1);
    chk("train_target",  32'(pred_target), 32'h0040);
    chk("train_next_pc", 32'(next_pc),     32'h0040);

    // Saturation high, then walk down.
    update_valid = 1'b1;
    repeat (5) tick();
    update_valid = 1'b0;
    #1 chk("sat_hi_taken", 32'(pred_taken), 32'h1);
    upd(1'b1, 16'h0010, 8'h00, 1'b0, 16'h0040, 1'b0);
    tick();
    #1 chk("dec1_taken", 32'(pred_taken), 32'h1);
    tick(); tick();
    update_valid = 1'b0;
    #1;
    chk("dec3_taken",   32'(pred_taken),  32'h0);
    chk("dec3_target",  32'(pred_target), 32'h0040);
    chk("dec3_next_pc", 32'(next_pc),     32'h0012);
    update_valid = 1'b1;
    repeat (2) tick();
    update_taken = 1'b1;
    tick();
    update_valid = 1'b0;
    #1 chk("sat_lo_taken", 32'(pred_taken), 32'h0);
    update_valid = 1'b1;
    repeat (2) tick();
    update_valid = 1'b0;
    #1 chk("retrain_taken", 32'(pred_taken), 32'h1);

    // Stalled BTB hit holds the GHR; release shifts in pred_taken.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_history", 32'(pred_history), 32'h00);
    end
    stall_pipeline = 1'b0;
    tick();
    stall_pipeline = 1'b1;
    #1 chk("spec_history", 32'(pred_history), 32'h01);

    // Repair beats speculation in the same cycle.
    stall_pipeline = 1'b0;
    upd(1'b1, 16'h0100, 8'hA5, 1'b0, 16'h0000, 1'b1);
    tick();
    update_valid = 1'b0; update_mispredict = 1'b0; stall_pipeline = 1'b1;
    #1 chk("repair_history", 32'(pred_history), 32'h4A);

    // Repair also applies while stalled.
    upd(1'b1, 16'h0100, 8'h3C, 1'b1, 16'h0200, 1'b1);
    tick();
    update_valid = 1'b0; update_mispredict = 1'b0;
    #1 chk("stall_repair_history", 32'(pred_history), 32'h79);

    // Lookup of an entry being written sees the old contents.
    fetch_pc = 16'h0020;
    upd(1'b1, 16'h0020, 8'h00, 1'b1, 16'h1234, 1'b0);
    #1 chk("hazard_old_target", 32'(pred_target), 32'h0000);
    tick();
    update_valid = 1'b0;
    #1 chk("hazard_new_target", 32'(pred_target), 32'h1234);

    fetch_pc = 16'hFFFE;
    #1 chk("wrap_next_pc", 32'(next_pc), 32'h0000);

    // Asynchronous reset between edges; update during reset is dropped.
    fetch_pc = 16'h0010;
    #1 chk("pre_rst_target", 32'(pred_target), 32'h0040);
    reset_n = 1'b0;
    #1;
    chk("arst_taken",   32'(pred_taken),   32'h0);
    chk("arst_target",  32'(pred_target),  32'h0);
    chk("arst_history", 32'(pred_history), 32'h00);
    chk("arst_next_pc", 32'(next_pc),      32'h0012);
    upd(1'b1, 16'h0030, 8'h00, 1'b1, 16'h0ABC, 1'b0);
    tick();
    reset_n = 1'b1;
    update_valid = 1'b0;
    fetch_pc = 16'h0030;
    #1 chk("dropped_upd_target", 32'(pred_target), 32'h0000);
    fetch_pc = 16'h0010;
    #1 chk("post_rst_miss_target", 32'(pred_target), 32'h0000);
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
